// File: rtl/regfile_arb_pkg.sv
// Shared definitions for the register-file access arbiter: FSM states,
// port identifiers and byte-lane count.
package regfile_arb_pkg;

  // Word width the byte strobes are built around.
  localparam int REG_BITS = 32;
  localparam int BYTES    = REG_BITS / 8;

  // Port identifiers, also used as the owner/last-grant encoding.
  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ACK    = 2'd2
  } arb_state_t;

endpackage

// File: rtl/regfile_mem.sv
// Single-port DEPTH x BITS register storage with per-byte write enables,
// a registered read that returns the pre-write contents, and a synchronous
// clear of every entry on reset.
module regfile_mem
  import regfile_arb_pkg::*;
#(
  parameter int BITS  = 32,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             we,
  input  logic [BYTES-1:0] wstrb,
  input  logic [AW-1:0]    addr,
  input  logic [BITS-1:0]  wdata,
  output logic [BITS-1:0]  rdata
);

  logic [BITS-1:0] mem [DEPTH];
  logic [BITS-1:0] rdata_reg;

  // Clear on reset; otherwise read old data and merge enabled byte lanes.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_reg <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (en) begin
      rdata_reg <= mem[addr];
      if (we) begin
        for (int b = 0; b < BYTES; b++) begin
          if (wstrb[b]) begin
            mem[addr][8*b +: 8] <= wdata[8*b +: 8];
          end
        end
      end
    end
  end

  assign rdata = rdata_reg;

endmodule

// File: rtl/regfile_access_arbiter.sv
// Round-robin arbiter sharing one byte-writable register file between the
// Wishbone decode (port A) and the logic-analyzer probes (port B). One
// transaction runs at a time: IDLE (grant) -> ACCESS (memory op) -> ACK
// (one-cycle ready to the winner).
module regfile_access_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int BITS  = 32,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             a_valid,
  input  logic             a_we,
  input  logic [BYTES-1:0] a_wstrb,
  input  logic [AW-1:0]    a_addr,
  input  logic [BITS-1:0]  a_wdata,
  output logic             a_ready,
  output logic [BITS-1:0]  a_rdata,
  input  logic             b_valid,
  input  logic             b_we,
  input  logic [AW-1:0]    b_addr,
  input  logic [BITS-1:0]  b_wdata,
  output logic             b_ready,
  output logic [BITS-1:0]  b_rdata,
  output logic             busy,
  output logic             owner
);

  arb_state_t       state_reg, state_next;
  logic             last_grant_reg;
  logic             grant;
  logic             grant_port;

  logic             lat_we_reg;
  logic [BYTES-1:0] lat_wstrb_reg;
  logic [AW-1:0]    lat_addr_reg;
  logic [BITS-1:0]  lat_wdata_reg;

  logic [BITS-1:0]  mem_rdata;
  logic [BITS-1:0]  a_hold_reg;
  logic [BITS-1:0]  b_hold_reg;

  // Arbitration and next-state: a tie goes to the port not granted last.
  always_comb begin
    grant      = 1'b0;
    grant_port = last_grant_reg;
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (a_valid && b_valid) begin
          grant      = 1'b1;
          grant_port = ~last_grant_reg;
        end else if (a_valid) begin
          grant      = 1'b1;
          grant_port = PORT_A;
        end else if (b_valid) begin
          grant      = 1'b1;
          grant_port = PORT_B;
        end
        if (grant) begin
          state_next = ACCESS;
        end
      end
      ACCESS:  state_next = ACK;
      ACK:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Capture the winner's request at grant time; B always writes all bytes.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_reg <= PORT_B;
      lat_we_reg     <= 1'b0;
      lat_wstrb_reg  <= '0;
      lat_addr_reg   <= '0;
      lat_wdata_reg  <= '0;
    end else if (grant) begin
      last_grant_reg <= grant_port;
      if (grant_port == PORT_A) begin
        lat_we_reg    <= a_we;
        lat_wstrb_reg <= a_wstrb;
        lat_addr_reg  <= a_addr;
        lat_wdata_reg <= a_wdata;
      end else begin
        lat_we_reg    <= b_we;
        lat_wstrb_reg <= '1;
        lat_addr_reg  <= b_addr;
        lat_wdata_reg <= b_wdata;
      end
    end
  end

  regfile_mem #(
    .BITS  (BITS),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .reset (reset),
    .en    (state_reg == ACCESS),
    .we    (lat_we_reg),
    .wstrb (lat_wstrb_reg),
    .addr  (lat_addr_reg),
    .wdata (lat_wdata_reg),
    .rdata (mem_rdata)
  );

  // Keep each port's last read result after its ACK cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_hold_reg <= '0;
      b_hold_reg <= '0;
    end else if (state_reg == ACK) begin
      if (last_grant_reg == PORT_A) begin
        a_hold_reg <= mem_rdata;
      end else begin
        b_hold_reg <= mem_rdata;
      end
    end
  end

  // During ACK the memory read register feeds the winner directly.
  assign a_ready = (state_reg == ACK) && (last_grant_reg == PORT_A);
  assign b_ready = (state_reg == ACK) && (last_grant_reg == PORT_B);
  assign a_rdata = a_ready ? mem_rdata : a_hold_reg;
  assign b_rdata = b_ready ? mem_rdata : b_hold_reg;
  assign busy    = (state_reg != IDLE);
  assign owner   = last_grant_reg;

endmodule

// File: tb/tb_regfile_access_arbiter.sv
// Bench for regfile_access_arbiter: directed scenarios followed by random
// traffic, all checked every cycle against a transaction-level model.
module tb_regfile_access_arbiter;

  logic        clk;
  logic        reset;
  logic        a_valid, a_we;
  logic [3:0]  a_wstrb, a_addr;
  logic [31:0] a_wdata, a_rdata;
  logic        a_ready;
  logic        b_valid, b_we;
  logic [3:0]  b_addr;
  logic [31:0] b_wdata, b_rdata;
  logic        b_ready;
  logic        busy, owner;

  regfile_access_arbiter dut (
    .clk     (clk),
    .reset   (reset),
    .a_valid (a_valid),
    .a_we    (a_we),
    .a_wstrb (a_wstrb),
    .a_addr  (a_addr),
    .a_wdata (a_wdata),
    .a_ready (a_ready),
    .a_rdata (a_rdata),
    .b_valid (b_valid),
    .b_we    (b_we),
    .b_addr  (b_addr),
    .b_wdata (b_wdata),
    .b_ready (b_ready),
    .b_rdata (b_rdata),
    .busy    (busy),
    .owner   (owner)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int vectors = 0;
  int miscompares = 0;
  int now = 0;

  // Transaction-level model: a grant at edge g gives ready after edge g+1
  // and the next grant may happen at edge g+3.
  logic [31:0] model_mem [16];
  bit          m_last;
  int          m_free_at, m_grant_at, m_a_done_at, m_b_done_at;
  logic [31:0] pend_a, pend_b, exp_a_rdata, exp_b_rdata;
  bit          a_granted, b_granted, keep_a, keep_b;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h at edge %0d", tag, obs, exp, now);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) model_mem[i] = 32'h0;
    m_last = 1'b1;
    m_free_at = 0;
    m_grant_at = -10;
    m_a_done_at = -10;
    m_b_done_at = -10;
    exp_a_rdata = 32'h0;
    exp_b_rdata = 32'h0;
    a_granted = 1'b0;
    b_granted = 1'b0;
  endtask

  task automatic set_a(bit we, logic [3:0] strb, logic [3:0] addr, logic [31:0] data);
    a_we = we; a_wstrb = strb; a_addr = addr; a_wdata = data; a_valid = 1'b1;
  endtask

  task automatic set_b(bit we, logic [3:0] addr, logic [31:0] data);
    b_we = we; b_addr = addr; b_wdata = data; b_valid = 1'b1;
  endtask

  // One clock: predict, advance, then compare every output.
  task automatic step();
    int k;
    bit w;
    logic [31:0] v;
    k = now + 1;
    if (reset) begin
      model_reset();
    end else if (k >= m_free_at && (a_valid || b_valid)) begin
      if (a_valid && b_valid) w = ~m_last;
      else w = b_valid;
      m_last = w;
      m_grant_at = k;
      m_free_at = k + 3;
      if (!w) begin
        pend_a = model_mem[a_addr];
        if (a_we) begin
          v = model_mem[a_addr];
          for (int i = 0; i < 4; i++)
            if (a_wstrb[i]) v[8*i +: 8] = a_wdata[8*i +: 8];
          model_mem[a_addr] = v;
        end
        m_a_done_at = k + 1;
        a_granted = 1'b1;
      end else begin
        pend_b = model_mem[b_addr];
        if (b_we) model_mem[b_addr] = b_wdata;
        m_b_done_at = k + 1;
        b_granted = 1'b1;
      end
    end
    @(posedge clk);
    now = k;
    @(negedge clk);
    if (m_a_done_at == now) exp_a_rdata = pend_a;
    if (m_b_done_at == now) exp_b_rdata = pend_b;
    chk("a_ready", {31'b0, a_ready}, {31'b0, m_a_done_at == now});
    chk("b_ready", {31'b0, b_ready}, {31'b0, m_b_done_at == now});
    chk("a_rdata", a_rdata, exp_a_rdata);
    chk("b_rdata", b_rdata, exp_b_rdata);
    chk("busy", {31'b0, busy}, {31'b0, (now == m_grant_at) || (now == m_grant_at + 1)});
    chk("owner", {31'b0, owner}, {31'b0, m_last});
    $display("edge %0d: a_ready=%0b b_ready=%0b busy=%0b owner=%0b a_rdata=%h b_rdata=%h",
             now, a_ready, b_ready, busy, owner, a_rdata, b_rdata);
    // Requester side: drop valid after completion unless holding on purpose.
    if (m_a_done_at == now) begin
      a_granted = 1'b0;
      if (keep_a) begin
        a_addr = 4'($urandom_range(0, 15));
        a_wdata = $urandom;
        a_we = 1'($urandom);
        a_wstrb = 4'($urandom);
      end else a_valid = 1'b0;
    end
    if (m_b_done_at == now) begin
      b_granted = 1'b0;
      if (keep_b) begin
        b_addr = 4'($urandom_range(0, 15));
        b_wdata = $urandom;
        b_we = 1'($urandom);
      end else b_valid = 1'b0;
    end
  endtask

  task automatic run_idle();
    int n;
    n = 0;
    while ((a_valid || b_valid || now < m_free_at - 1) && n < 60) begin
      step();
      n++;
    end
    chk("run_idle_bound", {31'b0, n < 60}, 32'h1);
  endtask

  initial begin
    reset = 1'b1;
    a_valid = 0; a_we = 0; a_wstrb = 0; a_addr = 0; a_wdata = 0;
    b_valid = 0; b_we = 0; b_addr = 0; b_wdata = 0;
    keep_a = 0; keep_b = 0;
    model_reset();
    @(negedge clk);
    step();
    step();
    reset = 1'b0;
    step();
    chk("reset_owner", {31'b0, owner}, 32'h1);
    chk("reset_busy", {31'b0, busy}, 32'h0);

    // A read of addr 3: ready two edges after valid is sampled.
    set_a(0, 4'h0, 4'd3, 32'h0);
    step();
    chk("lat_no_ready_yet", {31'b0, a_ready}, 32'h0);
    step();
    chk("lat_ready", {31'b0, a_ready}, 32'h1);
    chk("read3", a_rdata, 32'h0);
    run_idle();

    // Byte-strobed write then read-back.
    set_a(1, 4'b0101, 4'd5, 32'hDEADBEEF);
    run_idle();
    chk("write5_old", a_rdata, 32'h0);
    set_a(0, 4'h0, 4'd5, 32'h0);
    run_idle();
    chk("read5_merged", a_rdata, 32'h00AD00EF);

    // Simultaneous request after reset: A wins, B follows.
    reset = 1'b1;
    step();
    reset = 1'b0;
    set_a(0, 4'h0, 4'd2, 32'h0);
    set_b(1, 4'd2, 32'h11111111);
    run_idle();
    chk("tie_a_got_old", a_rdata, 32'h0);
    set_a(0, 4'h0, 4'd2, 32'h0);
    run_idle();
    chk("tie_b_wrote", a_rdata, 32'h11111111);

    // Both hold valid for six transactions: grants alternate.
    keep_a = 1; keep_b = 1;
    set_a(0, 4'h0, 4'd2, 32'h0);
    set_b(0, 4'd5, 32'h0);
    for (int i = 0; i < 18; i++) step();
    keep_a = 0; keep_b = 0;
    run_idle();

    // Reset during ACCESS aborts a B write to addr 15.
    set_b(1, 4'd15, 32'hCAFEF00D);
    step();
    chk("abort_busy", {31'b0, busy}, 32'h1);
    reset = 1'b1;
    b_valid = 1'b0;
    step();
    reset = 1'b0;
    step();
    chk("abort_idle", {31'b0, busy}, 32'h0);
    chk("abort_no_ready", {31'b0, b_ready}, 32'h0);
    set_a(0, 4'h0, 4'd15, 32'h0);
    run_idle();
    chk("abort_read15", a_rdata, 32'h0);

    // Write with empty strobe leaves the entry untouched.
    set_a(1, 4'hF, 4'd7, 32'h12345678);
    run_idle();
    set_a(1, 4'h0, 4'd7, 32'hFFFFFFFF);
    run_idle();
    chk("nostrb_old", a_rdata, 32'h12345678);
    set_a(0, 4'h0, 4'd7, 32'h0);
    run_idle();
    chk("nostrb_unchanged", a_rdata, 32'h12345678);

    // Random traffic; a waiting loser may change its inputs before grant.
    for (int i = 0; i < 400; i++) begin
      if (!a_valid && $urandom_range(0, 2) == 0)
        set_a(1'($urandom), 4'($urandom), 4'($urandom_range(0, 15)), $urandom);
      else if (a_valid && !a_granted && $urandom_range(0, 3) == 0)
        a_wdata = $urandom;
      if (!b_valid && $urandom_range(0, 2) == 0)
        set_b(1'($urandom), 4'($urandom_range(0, 15)), $urandom);
      else if (b_valid && !b_granted && $urandom_range(0, 3) == 0)
        b_addr = 4'($urandom_range(0, 15));
      step();
    end
    run_idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/regfile_access_arbiter.md
Name: regfile_access_arbiter

Overview:
- Shares one 16x32 byte-writable register file between two requesters:
  - Port A is driven from the Wishbone slave decode (cyc&stb, sel&we).
  - Port B is driven from logic-analyzer probes.
- Round-robin arbitration; one transaction in flight at a time.
- Each transaction completes with a one-cycle ready pulse to its owner.
- Sits between the user-project Wishbone/LA glue and the storage, replacing direct register access.

Parameters:
- BITS, 32, data width; must be 32 (byte strobes assume 4 bytes).
- DEPTH, 16, number of register entries.
- AW, 4, address width; must equal log2(DEPTH).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- a_valid  in  1  port A request; held until a_ready
- a_we  in  1  port A write enable
- a_wstrb  in  4  port A byte strobes; only used when a_we=1
- a_addr  in  AW  port A register index
- a_wdata  in  BITS  port A write data
- a_ready  out  1  port A completion pulse, one cycle
- a_rdata  out  BITS  port A read data; valid while a_ready=1
- b_valid  in  1  port B request; held until b_ready
- b_we  in  1  port B write enable; always a full-word write
- b_addr  in  AW  port B register index
- b_wdata  in  BITS  port B write data
- b_ready  out  1  port B completion pulse, one cycle
- b_rdata  out  BITS  port B read data; valid while b_ready=1
- busy  out  1  high in ACCESS and ACK states
- owner  out  1  0 = A, 1 = B; current or last granted port

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE, last_grant=1 (so A wins the first tie).
  - a_ready=b_ready=0, a_rdata=b_rdata=0, busy=0, owner=1.
  - All DEPTH entries cleared to 0.
- FSM IDLE -> ACCESS -> ACK -> IDLE, strictly sequential.
- IDLE:
  - If only a_valid or only b_valid is set, grant that port.
  - If both are set, grant the port that is not last_grant.
  - On a grant, latch we/wstrb/addr/wdata of the winner, set owner and last_grant, go to ACCESS.
  - If no valid is set, stay in IDLE.
- ACCESS, one cycle:
  - Read the latched entry into the winner's rdata register; the read returns the pre-write value.
  - If write: A writes only the bytes with wstrb[i]=1 (wdata[8i+7:8i]); B writes the full word.
  - Go to ACK.
- ACK:
  - Winner's ready=1 for exactly this cycle; the other port's ready stays 0.
  - Go to IDLE.
- Latency: valid sampled in IDLE at edge N, ready high during cycle N+2. Minimum request spacing is 3 cycles.
- A requester must deassert valid in the cycle after ready.
  - A valid still high in IDLE after its ACK is treated as a new request (back-to-back allowed).
- The losing requester keeps valid high. It is guaranteed service on the next IDLE, with no starvation, by the round-robin rule.
- Changes to the losing port's inputs while it waits are allowed. Its values are sampled only at its own grant.
- a_wstrb=0 with a_we=1: no bytes written; read and ready still occur.
- rdata holds its value after ready until the next grant to the same port.
- Reset mid-transaction: abort immediately. No write occurs if reset is asserted in ACCESS. Ready is not pulsed.
- Address is always in range, since DEPTH=2^AW; no wrap or error handling.

Decomposition:
- Package regfile_arb_pkg:
  - state encoding (IDLE, ACCESS, ACK).
  - PORT_A=0, PORT_B=1 constants.
  - BYTES=BITS/8.
- Sub-module regfile_mem:
  - DEPTH x BITS array with synchronous clear.
  - Single port, byte-enable write, registered read returning old data on write.
  - Keep the arbiter FSM in the top module.

Test Plan:
- Reset, then A read addr 3 -> a_ready pulse at cycle 2 after valid, a_rdata=0x00000000, b_ready stays 0.
- A write addr 5, wdata 0xDEADBEEF, wstrb 4'b0101 -> returns old value 0. A following A read of addr 5 -> a_rdata=0x00AD00EF.
- A and B both valid on the same edge after reset (B writes 0x11111111 to addr 2, A reads addr 2):
  - A is granted first and gets 0.
  - B completes 3 cycles later.
  - A second read of addr 2 returns 0x11111111.
- Both ports hold valid continuously for 6 transactions -> grants alternate A,B,A,B,A,B; owner toggles each ACCESS; each ready is a single-cycle pulse.
- B writes 0xCAFEF00D to addr 15 with reset asserted during ACCESS -> no b_ready. After reset, a read of addr 15 returns 0, state is IDLE, busy=0.
- A write to addr 7 with wstrb=0 after an earlier full write of 0x12345678 -> a_rdata=0x12345678 and the entry is unchanged.
